// File: rtl/arb_pkg.sv
// Shared types and the rotate/priority-pick/un-rotate winner selection used by
// the round-robin resource arbiter.
package arb_pkg;

   localparam int MAX_N = 16;
   localparam int PTR_W = 4;

   typedef enum logic [0:0] {IDLE, BUSY} arb_state_e;

   typedef struct packed {
      logic             found;
      logic [PTR_W-1:0] idx;
   } pick_t;

   // Rotate req so that index ptr lands at bit 0, isolate the lowest set bit,
   // then add ptr back (mod n) to recover the absolute requester index.
   function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                     input logic [PTR_W-1:0] ptr,
                                     input int               n);
      logic [MAX_N-1:0] rot;
      logic [MAX_N-1:0] lowest;
      logic [PTR_W-1:0] src;
      int               sum;
      int               off;
      pick_t            res;
      rot    = '0;
      res    = '0;
      off    = 0;
      for (int i = 0; i < MAX_N; i++) begin
         if (i < n) begin
            sum = int'(ptr) + i;
            if (sum >= n) sum = sum - n;
            src    = PTR_W'(sum);
            rot[i] = req[src];
         end
      end
      lowest = rot & (~rot + MAX_N'(1));
      for (int j = 0; j < MAX_N; j++) begin
         if (lowest[j]) off = j;
      end
      unique if (rot == '0) begin
         res.found = 1'b0;
      end else begin
         sum = int'(ptr) + off;
         if (sum >= n) sum = sum - n;
         res.found = 1'b1;
         res.idx   = PTR_W'(sum);
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter for one shared resource: a grant is held until the owner
// signals done or a watchdog of MAX_HOLD cycles forces it free.
module rr_resource_arbiter
   import arb_pkg::*;
#(
   parameter int  N        = 4,
   parameter int  MAX_HOLD = 16,
   localparam int IDW      = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic           done,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id,
   output logic           gnt_vld,
   output logic           timeout_err
);

   localparam int HW = $clog2(MAX_HOLD + 1);

   arb_state_e     state_q, state_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic [IDW-1:0] gnt_id_q, gnt_id_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [HW-1:0]  hold_q, hold_d;
   logic           timeout_q, timeout_d;
   pick_t          pick;

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;
      pick      = rr_pick(MAX_N'(req), PTR_W'(ptr_q), N);
      case (state_q)
         IDLE: begin
            if (pick.found) begin
               state_d  = BUSY;
               gnt_d    = N'(1) << pick.idx;
               gnt_id_d = IDW'(pick.idx);
               hold_d   = HW'(1);
            end
         end
         BUSY: begin
            // done wins over a coincident watchdog expiry, so no error pulse then.
            if (done || (hold_q == HW'(MAX_HOLD))) begin
               state_d   = IDLE;
               gnt_d     = '0;
               gnt_id_d  = '0;
               hold_d    = '0;
               timeout_d = ~done;
               ptr_d     = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + IDW'(1);
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         ptr_q     <= '0;
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt         = gnt_q;
   assign gnt_id      = gnt_id_q;
   assign gnt_vld     = |gnt_q;
   assign timeout_err = timeout_q;

   a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
   a_vld    : assert property (@(posedge clk) disable iff (rst) gnt_vld == (|gnt));
   a_id     : assert property (@(posedge clk) disable iff (rst) gnt_vld |-> gnt[gnt_id]);
   a_stable : assert property (@(posedge clk) disable iff (rst)
                               (state_q == BUSY && $past(state_q) == BUSY) |-> $stable(gnt_q));
   a_pulse  : assert property (@(posedge clk) disable iff (rst) timeout_err |=> !timeout_err);

endmodule
